// File: rtl/bsg_manycore_multi_link_credit_bridge_if.sv
// Bundle of per-channel credit/ready-valid signals between the endpoint
// bridges, the SDR link ports and the multi-link credit bridge.
interface bsg_manycore_multi_link_credit_bridge_if #(
    parameter int unsigned num_links_p = 3,
    parameter int unsigned fwd_width_p = 64,
    parameter int unsigned rev_width_p = 40
);
    logic [num_links_p-1:0]             ep_fwd_v_i;
    logic [num_links_p*fwd_width_p-1:0] ep_fwd_data_i;
    logic [num_links_p-1:0]             ep_fwd_credit_o;
    logic [num_links_p-1:0]             link_fwd_v_o;
    logic [num_links_p*fwd_width_p-1:0] link_fwd_data_o;
    logic [num_links_p-1:0]             link_fwd_ready_i;
    logic [num_links_p-1:0]             link_rev_v_i;
    logic [num_links_p*rev_width_p-1:0] link_rev_data_i;
    logic [num_links_p-1:0]             link_rev_ready_o;
    logic [num_links_p-1:0]             ep_rev_v_o;
    logic [num_links_p*rev_width_p-1:0] ep_rev_data_o;
    logic [num_links_p-1:0]             ep_rev_ready_i;
    logic [num_links_p-1:0]             flush_i;
    logic [num_links_p-1:0]             overflow_o;
    logic [num_links_p-1:0]             idle_o;

    // Bridge side
    modport slave (
        input  ep_fwd_v_i, ep_fwd_data_i, link_fwd_ready_i, link_rev_v_i, link_rev_data_i,
               ep_rev_ready_i, flush_i,
        output ep_fwd_credit_o, link_fwd_v_o, link_fwd_data_o, link_rev_ready_o, ep_rev_v_o,
               ep_rev_data_o, overflow_o, idle_o
    );

    // Endpoint/link side
    modport master (
        output ep_fwd_v_i, ep_fwd_data_i, link_fwd_ready_i, link_rev_v_i, link_rev_data_i,
               ep_rev_ready_i, flush_i,
        input  ep_fwd_credit_o, link_fwd_v_o, link_fwd_data_o, link_rev_ready_o, ep_rev_v_o,
               ep_rev_data_o, overflow_o, idle_o
    );
endinterface

// File: rtl/bsg_manycore_multi_link_credit_bridge.sv
// N independent channels. Forward: credit-flow endpoint -> FIFO -> ready/valid link,
// with flush (credit-preserving drain), sticky overflow and idle status.
// Reverse: ready/valid link -> 2-entry skid buffer -> ready/valid endpoint.
module bsg_manycore_multi_link_credit_bridge #(
    parameter int unsigned num_links_p = 3,
    parameter int unsigned fwd_width_p = 64,
    parameter int unsigned rev_width_p = 40,
    parameter int unsigned fwd_els_p   = 4
) (
    input logic clk_i,
    input logic reset_n_i,
    bsg_manycore_multi_link_credit_bridge_if.slave bus
);
    localparam int unsigned PtrW = $clog2(fwd_els_p);
    localparam int unsigned CntW = $clog2(fwd_els_p + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(fwd_els_p);

    typedef enum logic {StRun, StFlush} state_e;

    for (genvar c = 0; c < num_links_p; c++) begin : g_ch
        // Forward path state
        logic [fwd_width_p-1:0] r_mem [fwd_els_p];
        logic [PtrW-1:0]        r_wr_ptr, r_rd_ptr;
        logic [CntW-1:0]        r_fwd_cnt, w_fwd_cnt_d;
        state_e                 r_state, w_state_d;
        logic                   r_credit, r_overflow, r_idle;
        logic                   w_enq_v, w_full, w_fwd_valid, w_deq, w_push, w_ovf;

        // Reverse path state
        logic [rev_width_p-1:0] r_rev_mem [2];
        logic                   r_rev_wr, r_rev_rd;
        logic [1:0]             r_rev_cnt, w_rev_cnt_d;
        logic                   r_rev_ready;
        logic                   w_rev_push, w_rev_pop;

        assign w_enq_v     = bus.ep_fwd_v_i[c];
        assign w_full      = (r_fwd_cnt == FullCnt);
        assign w_fwd_valid = (r_state == StRun) && (r_fwd_cnt != '0);
        // In FLUSH one entry is discarded per cycle instead of waiting for the link
        assign w_deq       = (r_state == StRun) ? (w_fwd_valid && bus.link_fwd_ready_i[c])
                                                : (r_fwd_cnt != '0);
        // A full FIFO still accepts when an entry leaves in the same cycle
        assign w_push      = w_enq_v && (!w_full || w_deq);
        assign w_ovf       = w_enq_v && w_full && !w_deq;

        // Forward occupancy next-state
        always_comb begin
            w_fwd_cnt_d = r_fwd_cnt;
            if (w_push && !w_deq) begin
                w_fwd_cnt_d = r_fwd_cnt + 1'b1;
            end else if (!w_push && w_deq) begin
                w_fwd_cnt_d = r_fwd_cnt - 1'b1;
            end
        end

        // RUN/FLUSH next-state; a packet arriving in the last flush cycle is flushed too
        always_comb begin
            w_state_d = r_state;
            case (r_state)
                StRun: begin
                    if (bus.flush_i[c]) w_state_d = StFlush;
                end
                StFlush: begin
                    if ((r_fwd_cnt == '0) && !bus.flush_i[c] && !w_enq_v) w_state_d = StRun;
                end
                default: w_state_d = StRun;
            endcase
        end

        // Reverse occupancy next-state
        assign w_rev_push = bus.link_rev_v_i[c] && r_rev_ready;
        assign w_rev_pop  = (r_rev_cnt != 2'd0) && bus.ep_rev_ready_i[c];

        always_comb begin
            w_rev_cnt_d = r_rev_cnt;
            if (w_rev_push && !w_rev_pop) begin
                w_rev_cnt_d = r_rev_cnt + 2'd1;
            end else if (!w_rev_push && w_rev_pop) begin
                w_rev_cnt_d = r_rev_cnt - 2'd1;
            end
        end

        // Channel control state, credits, flags and status
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_state     <= StRun;
                r_fwd_cnt   <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_credit    <= 1'b0;
                r_overflow  <= 1'b0;
                r_idle      <= 1'b1;
                r_rev_cnt   <= 2'd0;
                r_rev_wr    <= 1'b0;
                r_rev_rd    <= 1'b0;
                r_rev_ready <= 1'b0;
            end else begin
                r_state   <= w_state_d;
                r_fwd_cnt <= w_fwd_cnt_d;
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_deq)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_credit  <= w_deq;
                if (w_ovf)  r_overflow <= 1'b1;
                r_rev_cnt <= w_rev_cnt_d;
                if (w_rev_push) r_rev_wr <= ~r_rev_wr;
                if (w_rev_pop)  r_rev_rd <= ~r_rev_rd;
                r_rev_ready <= (w_rev_cnt_d != 2'd2);
                // Idle reflects the state being loaded this edge
                r_idle    <= (w_state_d == StRun) && (w_fwd_cnt_d == '0) &&
                             (w_rev_cnt_d == 2'd0) && !w_deq;
            end
        end

        // Payload storage; not reset since occupancy gates its use
        always_ff @(posedge clk_i) begin
            if (w_push)     r_mem[r_wr_ptr]     <= bus.ep_fwd_data_i[c*fwd_width_p +: fwd_width_p];
            if (w_rev_push) r_rev_mem[r_rev_wr] <= bus.link_rev_data_i[c*rev_width_p +: rev_width_p];
        end

        assign bus.link_fwd_v_o[c]                                 = w_fwd_valid;
        assign bus.link_fwd_data_o[c*fwd_width_p +: fwd_width_p]   = r_mem[r_rd_ptr];
        assign bus.ep_fwd_credit_o[c]                              = r_credit;
        assign bus.overflow_o[c]                                   = r_overflow;
        assign bus.idle_o[c]                                       = r_idle;
        assign bus.link_rev_ready_o[c]                             = r_rev_ready;
        assign bus.ep_rev_v_o[c]                                   = (r_rev_cnt != 2'd0);
        assign bus.ep_rev_data_o[c*rev_width_p +: rev_width_p]     = r_rev_mem[r_rev_rd];
    end
endmodule

// File: tb/tb_bsg_manycore_multi_link_credit_bridge.sv
// Scoreboard bench: a queue-based reference model predicts per-channel packet order,
// credits, overflow, idle and reverse-path readiness; a monitor checks link outputs.
module tb_bsg_manycore_multi_link_credit_bridge;
    localparam int NL = 3;
    localparam int FW = 64;
    localparam int RW = 40;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bsg_manycore_multi_link_credit_bridge_if #(
        .num_links_p(NL), .fwd_width_p(FW), .rev_width_p(RW)
    ) bus ();

    bsg_manycore_multi_link_credit_bridge #(
        .num_links_p(NL), .fwd_width_p(FW), .rev_width_p(RW), .fwd_els_p(D)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state
    logic [FW-1:0] fsb [NL][$];
    logic [RW-1:0] rsb [NL][$];
    int m_fcnt [NL];
    int m_rcnt [NL];
    bit m_fl [NL];
    bit m_cred [NL];
    bit m_ovf [NL];
    bit m_rrdy [NL];
    bit hs_rev [NL];

    // Driver bookkeeping
    int cred [NL];
    int sent [NL];
    int cred_seen [NL];
    int rev_left [NL];
    int rev_sent [NL];
    int rev_rx [NL];
    int rev_id = 0;
    bit rev_dense = 1'b0;

    task automatic chk(input string name, input int ch, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s ch%0d: got %h, expected %h at %0t", name, ch, act, exp, $time);
        end
    endtask

    // Model: runs mid-cycle with inputs and outputs stable
    initial begin
        bit exp_v, deq, rpush, rpop;
        int old_cnt;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NL; c++) begin
                if (!rst_n) begin
                    fsb[c].delete();
                    rsb[c].delete();
                    m_fcnt[c] = 0;
                    m_rcnt[c] = 0;
                    m_fl[c]   = 1'b0;
                    m_cred[c] = 1'b0;
                    m_ovf[c]  = 1'b0;
                    m_rrdy[c] = 1'b0;
                end else begin
                    exp_v = !m_fl[c] && (m_fcnt[c] != 0);
                    chk("fwd_valid", c, 64'(bus.link_fwd_v_o[c]), 64'(exp_v));
                    chk("credit", c, 64'(bus.ep_fwd_credit_o[c]), 64'(m_cred[c]));
                    chk("overflow", c, 64'(bus.overflow_o[c]), 64'(m_ovf[c]));
                    chk("idle", c, 64'(bus.idle_o[c]),
                        64'(!m_fl[c] && m_fcnt[c] == 0 && m_rcnt[c] == 0 && !m_cred[c]));
                    chk("rev_valid", c, 64'(bus.ep_rev_v_o[c]), 64'(m_rcnt[c] != 0));
                    chk("rev_ready", c, 64'(bus.link_rev_ready_o[c]), 64'(m_rrdy[c]));

                    old_cnt = m_fcnt[c];
                    deq = m_fl[c] ? (old_cnt != 0) : (exp_v && bus.link_fwd_ready_i[c]);
                    if (m_fl[c] && deq && fsb[c].size() != 0) void'(fsb[c].pop_front());
                    if (deq) m_fcnt[c]--;
                    if (bus.ep_fwd_v_i[c]) begin
                        if (old_cnt < D || deq) begin
                            fsb[c].push_back(bus.ep_fwd_data_i[c*FW +: FW]);
                            m_fcnt[c]++;
                        end else begin
                            m_ovf[c] = 1'b1;
                        end
                    end
                    m_cred[c] = deq;
                    if (!m_fl[c]) m_fl[c] = bus.flush_i[c];
                    else if (old_cnt == 0 && !bus.flush_i[c] && !bus.ep_fwd_v_i[c]) m_fl[c] = 1'b0;

                    rpop  = (m_rcnt[c] != 0) && bus.ep_rev_ready_i[c];
                    rpush = bus.link_rev_v_i[c] && m_rrdy[c];
                    if (rpush) rsb[c].push_back(bus.link_rev_data_i[c*RW +: RW]);
                    m_rcnt[c] = m_rcnt[c] + int'(rpush) - int'(rpop);
                    m_rrdy[c] = (m_rcnt[c] < 2);
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes an output handshake
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int c = 0; c < NL; c++) begin
                if (!rst_n) begin
                    hs_rev[c] = 1'b0;
                end else begin
                    hs_rev[c] = bus.link_rev_v_i[c] && bus.link_rev_ready_o[c];
                    if (bus.link_fwd_v_o[c] && bus.link_fwd_ready_i[c]) begin
                        chk("fwd_expected", c, 64'(fsb[c].size() != 0), 64'd1);
                        if (fsb[c].size() != 0)
                            chk("fwd_data", c, bus.link_fwd_data_o[c*FW +: FW], fsb[c].pop_front());
                    end
                    if (bus.ep_rev_v_o[c] && bus.ep_rev_ready_i[c]) begin
                        rev_rx[c]++;
                        chk("rev_expected", c, 64'(rsb[c].size() != 0), 64'd1);
                        if (rsb[c].size() != 0)
                            chk("rev_data", c, 64'(bus.ep_rev_data_o[c*RW +: RW]),
                                64'(rsb[c].pop_front()));
                    end
                end
            end
        end
    end

    // Advance one cycle; count credits and run the held-until-accepted reverse source
    task automatic step();
        @(posedge clk);
        #1;
        for (int c = 0; c < NL; c++) begin
            if (bus.ep_fwd_credit_o[c]) begin
                cred[c]++;
                cred_seen[c]++;
            end
            if (bus.link_rev_v_i[c] && hs_rev[c]) bus.link_rev_v_i[c] = 1'b0;
            if (!bus.link_rev_v_i[c] && rev_left[c] > 0 &&
                (rev_dense || $urandom_range(3) != 0)) begin
                bus.link_rev_v_i[c] = 1'b1;
                bus.link_rev_data_i[c*RW +: RW] = {8'(c), 32'(rev_id)};
                rev_id++;
                rev_left[c]--;
                rev_sent[c]++;
            end
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_fwd_v", 0, 64'(bus.link_fwd_v_o), 64'd0);
        chk("rst_credit", 0, 64'(bus.ep_fwd_credit_o), 64'd0);
        chk("rst_rev_v", 0, 64'(bus.ep_rev_v_o), 64'd0);
        chk("rst_overflow", 0, 64'(bus.overflow_o), 64'd0);
        chk("rst_rev_ready", 0, 64'(bus.link_rev_ready_o), 64'd0);
        chk("rst_idle", 0, 64'(bus.idle_o), 64'((1 << NL) - 1));
    endtask

    task automatic clear_inputs();
        bus.ep_fwd_v_i       = '0;
        bus.ep_fwd_data_i    = '0;
        bus.link_fwd_ready_i = '1;
        bus.link_rev_v_i     = '0;
        bus.link_rev_data_i  = '0;
        bus.ep_rev_ready_i   = '1;
        bus.flush_i          = '0;
        for (int c = 0; c < NL; c++) rev_left[c] = 0;
    endtask

    initial begin
        int snap;
        for (int c = 0; c < NL; c++) begin
            cred[c] = D; sent[c] = 0; cred_seen[c] = 0;
            rev_left[c] = 0; rev_sent[c] = 0; rev_rx[c] = 0;
        end
        clear_inputs();
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_rev_ready", 0, 64'(bus.link_rev_ready_o), 64'((1 << NL) - 1));

        // Ch0: four back-to-back packets with the link always ready
        cred_seen[0] = 0;
        for (int i = 0; i < 4; i++) begin
            bus.ep_fwd_v_i[0] = 1'b1;
            bus.ep_fwd_data_i[0 +: FW] = 64'hA0 + 64'(i);
            step();
        end
        bus.ep_fwd_v_i[0] = 1'b0;
        repeat (8) step();
        chk("ch0_credits", 0, 64'(cred_seen[0]), 64'd4);
        chk("ch0_idle", 0, 64'(bus.idle_o[0]), 64'd1);

        // Ch1: five packets into a stalled link, fifth overflows
        cred_seen[1] = 0;
        bus.link_fwd_ready_i[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.ep_fwd_v_i[1] = 1'b1;
            bus.ep_fwd_data_i[FW +: FW] = 64'hB0 + 64'(i);
            step();
        end
        bus.ep_fwd_v_i[1] = 1'b0;
        chk("ch1_overflow_set", 1, 64'(bus.overflow_o[1]), 64'd1);
        repeat (3) step();
        bus.link_fwd_ready_i[1] = 1'b1;
        repeat (8) step();
        chk("ch1_credits", 1, 64'(cred_seen[1]), 64'd4);
        chk("ch1_overflow_sticky", 1, 64'(bus.overflow_o[1]), 64'd1);

        // Ch2: three held packets, flush pulse, one more arrives during the flush
        cred_seen[2] = 0;
        bus.link_fwd_ready_i[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ep_fwd_v_i[2] = 1'b1;
            bus.ep_fwd_data_i[2*FW +: FW] = 64'hC0 + 64'(i);
            step();
        end
        bus.ep_fwd_v_i[2] = 1'b0;
        bus.flush_i[2] = 1'b1;
        step();
        bus.flush_i[2] = 1'b0;
        bus.ep_fwd_v_i[2] = 1'b1;
        bus.ep_fwd_data_i[2*FW +: FW] = 64'hC3;
        step();
        bus.ep_fwd_v_i[2] = 1'b0;
        repeat (8) step();
        chk("ch2_credits", 2, 64'(cred_seen[2]), 64'd4);
        chk("ch2_fwd_v", 2, 64'(bus.link_fwd_v_o[2]), 64'd0);
        chk("ch2_idle", 2, 64'(bus.idle_o[2]), 64'd1);
        bus.link_fwd_ready_i[2] = 1'b1;

        // All channels: credit-gated random forward traffic, random readiness both ways
        for (int c = 0; c < NL; c++) begin
            cred[c] = D; sent[c] = 0; cred_seen[c] = 0;
            rev_left[c] = 40; rev_sent[c] = 0; rev_rx[c] = 0;
        end
        rev_dense = 1'b0;
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NL; c++) begin
                bus.link_fwd_ready_i[c] = ($urandom_range(3) != 0);
                bus.ep_rev_ready_i[c]   = 1'($urandom_range(1));
                if (cred[c] > 0 && $urandom_range(3) != 0) begin
                    bus.ep_fwd_v_i[c] = 1'b1;
                    bus.ep_fwd_data_i[c*FW +: FW] = {8'(c), 24'(sent[c]), 32'($urandom)};
                    cred[c]--;
                    sent[c]++;
                end else begin
                    bus.ep_fwd_v_i[c] = 1'b0;
                end
            end
            step();
        end
        bus.ep_fwd_v_i = '0;
        bus.link_fwd_ready_i = '1;
        bus.ep_rev_ready_i = '1;
        rev_dense = 1'b1;
        repeat (60) step();
        for (int c = 0; c < NL; c++) begin
            chk("rand_credit_total", c, 64'(cred_seen[c]), 64'(sent[c]));
            chk("rand_fwd_drained", c, 64'(fsb[c].size()), 64'd0);
            chk("rand_rev_count", c, 64'(rev_rx[c]), 64'(rev_sent[c]));
        end

        // Reverse: eight packets streamed while the endpoint toggles ready
        snap = rev_rx[0];
        rev_left[0] = 8;
        for (int i = 0; i < 20; i++) begin
            bus.ep_rev_ready_i[0] = (i % 2 == 0);
            step();
        end
        bus.ep_rev_ready_i[0] = 1'b1;
        repeat (5) step();
        chk("rev_toggle_count", 0, 64'(rev_rx[0] - snap), 64'd8);

        // Reset with two forward and one reverse packet held
        bus.link_fwd_ready_i[0] = 1'b0;
        bus.ep_rev_ready_i[0] = 1'b0;
        rev_left[0] = 1;
        for (int i = 0; i < 2; i++) begin
            bus.ep_fwd_v_i[0] = 1'b1;
            bus.ep_fwd_data_i[0 +: FW] = 64'hD0 + 64'(i);
            step();
        end
        bus.ep_fwd_v_i[0] = 1'b0;
        repeat (2) step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst2_idle", 0, 64'(bus.idle_o), 64'((1 << NL) - 1));
        chk("post_rst2_rev_ready", 0, 64'(bus.link_rev_ready_o), 64'((1 << NL) - 1));
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
